// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: reads two operands, drives the ALU, writes back the result.
// Keeps sticky overflow/zero status and a count of completed legal operations.
//
// state | meaning
// IDLE  | ready for an instruction; latches op/rd/rs/rt on accept
// READ  | register-file addresses driven, operands captured at the edge
// EXEC  | ALU driven from captured operands, result/flags captured at the edge
// WB    | one-cycle done pulse; write-back and status update for legal ops
module alu_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rt,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              done,
    output logic              err,
    output logic              sticky_ovf,
    output logic              sticky_zero,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t              r_state;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_illegal;
    logic [ADDR_W-1:0]   r_raddr1;
    logic [ADDR_W-1:0]   r_raddr2;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [3:0]          r_alu_ctrl;
    logic                r_ovf;
    logic                r_zero;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;
    logic                r_err;
    logic                r_sticky_ovf;
    logic                r_sticky_zero;
    logic [15:0]         r_count;
    logic                w_legal;

    always_comb begin
        w_legal = 1'b0;
        case (instr_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1010, 4'b1100, 4'b1110,
            4'b1001: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign instr_ready = (r_state == S_IDLE) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_rd          <= '0;
            r_illegal     <= 1'b0;
            r_raddr1      <= '0;
            r_raddr2      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctrl    <= '0;
            r_ovf         <= 1'b0;
            r_zero        <= 1'b0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_sticky_ovf  <= 1'b0;
            r_sticky_zero <= 1'b0;
            r_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        r_op     <= instr_op;
                        r_rd     <= instr_rd;
                        r_raddr1 <= instr_rs;
                        r_raddr2 <= instr_rt;
                        if (w_legal) begin
                            r_illegal <= 1'b0;
                            r_state   <= S_READ;
                        end else begin
                            r_illegal <= 1'b1;
                            r_done    <= 1'b1;
                            r_err     <= 1'b1;
                            r_state   <= S_WB;
                        end
                    end
                end
                S_READ: begin
                    r_alu_a    <= rf_rdata1;
                    r_alu_b    <= rf_rdata2;
                    r_alu_ctrl <= r_op;
                    r_state    <= S_EXEC;
                end
                S_EXEC: begin
                    r_ovf   <= alu_overflow;
                    r_zero  <= alu_zero;
                    r_wdata <= alu_s;
                    r_waddr <= r_rd;
                    r_we    <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_we   <= 1'b0;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (!r_illegal) begin
                        r_count       <= r_count + 16'd1;
                        r_sticky_zero <= r_zero;
                        r_sticky_ovf  <= r_sticky_ovf | r_ovf;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rf_raddr1   = r_raddr1;
    assign rf_raddr2   = r_raddr2;
    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign done        = r_done;
    assign err         = r_err;
    assign sticky_ovf  = r_sticky_ovf;
    assign sticky_zero = r_sticky_zero;
    assign op_count    = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file and ALU.
// Expected values are hand-computed per vector.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [2:0]  instr_rd = '0;
    logic [2:0]  instr_rs = '0;
    logic [2:0]  instr_rt = '0;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_ctrl;
    logic        alu_overflow, alu_zero;
    logic        done, err, sticky_ovf, sticky_zero;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0;

    logic [15:0] rf [0:7];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_s(alu_s), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .done(done), .err(err),
        .sticky_ovf(sticky_ovf), .sticky_zero(sticky_zero), .op_count(op_count)
    );

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            we_cnt <= we_cnt + 1;
        end else if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end
    end

    always_comb begin
        alu_s        = '0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0000: begin
                alu_s = alu_a - alu_b;
                alu_overflow = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'b0001: begin
                alu_s = alu_a + alu_b;
                alu_overflow = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'b0010: alu_s = alu_a | alu_b;
            4'b0011: alu_s = alu_a & alu_b;
            4'b0100: alu_s = alu_a - 16'd1;
            4'b0101: alu_s = alu_a + 16'd1;
            4'b0110: alu_s = ~alu_a;
            4'b1000, 4'b1100: alu_s = alu_a << 1;
            4'b1010: alu_s = alu_a >> 1;
            4'b1110: alu_s = {alu_a[15], alu_a[15:1]};
            4'b1001: alu_s = ($signed(alu_a) <= $signed(alu_b)) ? 16'd1 : 16'd0;
            default: alu_s = '0;
        endcase
        alu_zero = (alu_s == 16'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input bit illegal, input logic [15:0] exp_wdata);
        int lat;
        int we0;
        lat = 0;
        @(negedge clk);
        check("ready_in_idle", instr_ready, 1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        we0 = we_cnt;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1 && !illegal) begin
                check("read_raddr1", rf_raddr1, rs);
                check("read_raddr2", rf_raddr2, rt);
                check("ready_low_read", instr_ready, 0);
            end
            if (c == 2 && !illegal) check("exec_ctrl", alu_ctrl, op);
            if (done) begin
                lat = c;
                check("wb_err", err, illegal);
                check("wb_we", rf_we, !illegal);
                check("wb_ready_low", instr_ready, 0);
                if (!illegal) begin
                    check("wb_waddr", rf_waddr, rd);
                    check("wb_wdata", rf_wdata, exp_wdata);
                end
            end
        end
        check("latency", lat, illegal ? 1 : 3);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("we_cleared", rf_we, 0);
        check("err_cleared", err, 0);
        check("we_pulses", we_cnt - we0, illegal ? 0 : 1);
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
    } instr_t;

    initial begin
        instr_t q [0:2];
        int acc [0:2];
        int idx, low_cnt, done_cnt, cnt0;

        // Reset state
        #1;
        check("rst_ready", instr_ready, 0);
        check("rst_done", done, 0);
        check("rst_we", rf_we, 0);
        check("rst_count", op_count, 0);
        check("rst_alu_a", alu_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", instr_ready, 1);

        preset(3'd1, 16'h0001);
        preset(3'd2, 16'h0001);
        run_op(4'b0001, 3'd3, 3'd1, 3'd2, 0, 16'h0002);
        check("add_count", op_count, 1);
        check("add_zero", sticky_zero, 0);
        check("add_ovf", sticky_ovf, 0);

        run_op(4'b0000, 3'd4, 3'd1, 3'd2, 0, 16'h0000);
        check("sub_count", op_count, 2);
        check("sub_zero", sticky_zero, 1);
        check("rf4_sub", rf[4], 16'h0000);

        preset(3'd1, 16'h7FFF);
        run_op(4'b0001, 3'd5, 3'd1, 3'd2, 0, 16'h8000);
        check("ovf_set", sticky_ovf, 1);
        check("ovf_zero", sticky_zero, 0);
        check("ovf_count", op_count, 3);

        run_op(4'b0010, 3'd6, 3'd1, 3'd2, 0, 16'h7FFF);
        check("ovf_sticky", sticky_ovf, 1);
        check("or_count", op_count, 4);

        run_op(4'b0111, 3'd7, 3'd1, 3'd2, 1, 16'h0000);
        check("illegal_count", op_count, 4);
        check("illegal_ovf", sticky_ovf, 1);
        check("illegal_zero", sticky_zero, 0);

        // Three queued ops with instr_valid held high; B and C depend on A and B.
        preset(3'd1, 16'h0010);
        preset(3'd2, 16'h0003);
        q[0] = '{op: 4'b0001, rd: 3'd3, rs: 3'd1, rt: 3'd2};
        q[1] = '{op: 4'b0001, rd: 3'd4, rs: 3'd3, rt: 3'd2};
        q[2] = '{op: 4'b0011, rd: 3'd5, rs: 3'd4, rt: 3'd1};
        idx = 0; low_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 3; k++) acc[k] = -100;
        @(negedge clk);
        instr_valid = 1'b1;
        {instr_op, instr_rd, instr_rs, instr_rt} = q[0];
        for (int cyc = 0; cyc < 40 && done_cnt < 3; cyc++) begin
            bit take;
            take = instr_valid && instr_ready;
            if (take) acc[idx] = cyc;
            if (!instr_ready) low_cnt++;
            if (done) done_cnt++;
            @(posedge clk);
            #1;
            if (take) begin
                idx++;
                if (idx == 3) instr_valid = 1'b0;
                else {instr_op, instr_rd, instr_rs, instr_rt} = q[idx];
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("q_done_cnt", done_cnt, 3);
        check("q_accepts", idx, 3);
        check("q_gap1", acc[1] - acc[0], 4);
        check("q_gap2", acc[2] - acc[1], 4);
        check("q_ready_low", low_cnt, 9);
        @(negedge clk);
        check("q_r3", rf[3], 16'h0013);
        check("q_r4", rf[4], 16'h0016);
        check("q_r5", rf[5], 16'h0010);
        check("q_count", op_count, 7);
        check("q_we_total", we_cnt, 7);

        // Reset while in EXEC abandons the op.
        preset(3'd6, 16'hABCD);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'b0001; instr_rd = 3'd6; instr_rs = 3'd1; instr_rt = 3'd2;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("exec_alu_a", alu_a, 16'h0010);
        check("exec_alu_b", alu_b, 16'h0003);
        cnt0 = we_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", instr_ready, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_ctrl", alu_ctrl, 0);
        check("mid_rst_raddr1", rf_raddr1, 0);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_ovf", sticky_ovf, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", instr_ready, 1);
        repeat (3) @(negedge clk);
        check("rst_no_we", we_cnt - cnt0, 0);
        check("rst_r6_kept", rf[6], 16'hABCD);

        run_op(4'b0001, 3'd7, 3'd1, 3'd2, 0, 16'h0013);
        check("after_rst_count", op_count, 1);
        check("after_rst_ovf", sticky_ovf, 0);
        check("after_rst_r7", rf[7], 16'h0013);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that executes one register-to-register ALU operation at a time: reads two operands from the register file, drives the 16-bit ALU, and writes the result back.
- Sits between an instruction source (valid/ready handshake) and the existing combinational ALU and register file.
- Keeps sticky status flags and a completed-operation counter.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- ADDR_W, 3, register-file address width (8 registers).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction request.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  ALU operation code; same encoding as the ALU control input.
- instr_rd  in  ADDR_W  destination register.
- instr_rs  in  ADDR_W  source register A.
- instr_rt  in  ADDR_W  source register B.
- rf_raddr1  out  ADDR_W  register-file read address A.
- rf_raddr2  out  ADDR_W  register-file read address B.
- rf_rdata1  in  DATA_W  read data A; combinational from rf_raddr1.
- rf_rdata2  in  DATA_W  read data B; combinational from rf_raddr2.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_ctrl  out  4  ALU control.
- alu_s  in  DATA_W  ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_zero  in  1  ALU zero flag.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; illegal opcode.
- sticky_ovf  out  1  set when a legal op completes with overflow.
- sticky_zero  out  1  mirrors zero flag of the last legal op.
- op_count  out  16  count of legal completed ops; wraps 0xFFFF to 0.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0, except instr_ready = 1 once reset is released.
  - All internal registers cleared.
  - An operation in flight is abandoned; no rf_we is issued.
- Legal opcodes (all others are illegal):
  - 0000 sub, 0001 add, 0010 or, 0011 and
  - 0100 dec, 0101 inc, 0110 invert
  - 1000 lsl, 1010 lsr, 1100 asl, 1110 asr
  - 1001 set-on-less-than-or-equal
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch op, rd, rs, rt.
  - Next state READ if op is legal; WB with an error flag latched if illegal.
- READ:
  - rf_raddr1 = rs_q, rf_raddr2 = rt_q.
  - At the edge, capture rf_rdata1/rf_rdata2 into a_q/b_q; go to EXEC.
- EXEC:
  - alu_a = a_q, alu_b = b_q, alu_ctrl = op_q.
  - At the edge, capture alu_s, alu_overflow and alu_zero; go to WB.
- WB (exactly one cycle), then IDLE:
  - done = 1; err = error flag.
  - If legal:
    - rf_we = 1, rf_waddr = rd_q, rf_wdata = captured result.
    - op_count increments.
    - sticky_zero <= captured zero.
    - sticky_ovf <= sticky_ovf | captured overflow.
  - If illegal: rf_we = 0; counter and flags unchanged.
- Output holding:
  - alu_a, alu_b, alu_ctrl, rf_raddr1 and rf_raddr2 are registered and hold their last values outside their active state.
  - rf_we, done and err are 0 outside WB.
- Handshake:
  - instr_ready = 0 in READ, EXEC and WB.
  - instr_valid is ignored when not ready.
  - An instruction presented during WB is accepted on the first IDLE cycle.
- Latency:
  - Legal op: accept at edge N; done and rf_we high in the cycle after edge N+2, i.e. 3 cycles after acceptance.
  - Illegal op: done after 1 cycle.
  - Throughput: one legal op per 4 cycles.
- Hazards:
  - rd may equal rs or rt; operands were captured in READ, so no hazard arises.
  - Back-to-back ops see the previous writeback, because READ follows WB by at least one IDLE cycle.

Test Plan:
- Reset, then R1=0x0001, R2=0x0001, add(0001) rd=3 rs=1 rt=2 -> done 3 cycles after accept; rf_we with waddr 3, wdata 0x0002; op_count=1; sticky_zero=0.
- sub(0000) rd=4 rs=1 rt=2 (1-1) -> wdata 0x0000, sticky_zero=1.
- R1=0x7FFF, R2=0x0001, add -> wdata 0x8000 and sticky_ovf=1. A following no-overflow op leaves sticky_ovf=1.
- Illegal op 0111 -> done and err high 1 cycle after accept, rf_we never asserted, op_count unchanged.
- Hold instr_valid high with 3 queued ops -> exactly one accept per 4 cycles; instr_ready low in READ/EXEC/WB. Second op reads rs = first op's rd and sees the new value.
- Assert rst_n=0 during EXEC -> all outputs 0 immediately, no rf_we pulse, state IDLE after release.
